// File: rtl/lfsr_ctrl_pkg.sv
// Shared definitions for the LFSR step sequencer: FSM encoding, datapath width, reset seed.
// Imported by the sequencer top.
package lfsr_ctrl_pkg;

   localparam int LFSR_W = 8;
   localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'h80;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/lfsr_step_ctrl_if.sv
// Request/response bundle between the pattern logic (master) and the LFSR step sequencer (slave).
// Handshake: req_i is held until ready_o; done_o pulses once with result_o valid.
interface lfsr_step_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             req_i;
   logic [7:0]       seed_i;
   logic [CNT_W-1:0] steps_i;
   logic             abort_i;
   logic             ready_o;
   logic             busy_o;
   logic             done_o;
   logic [7:0]       result_o;
   logic             zero_seed_o;

   modport master (
      output req_i, seed_i, steps_i, abort_i,
      input  ready_o, busy_o, done_o, result_o, zero_seed_o
   );

   modport slave (
      input  req_i, seed_i, steps_i, abort_i,
      output ready_o, busy_o, done_o, result_o, zero_seed_o
   );
endinterface

// File: rtl/lfsr_2.sv
// 8-bit LFSR core: rst_i synchronously loads val, start_i advances one step per cycle.
// result is the state register itself.
module lfsr_2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] val,
   input  logic       start_i,
   output logic [7:0] result
);
   logic [7:0] r_state;
   logic [7:0] w_next;

   assign w_next = {r_state[6] ^ r_state[7], r_state[5] ^ r_state[7], r_state[4], r_state[3],
                    r_state[2], r_state[1] ^ r_state[7], r_state[1], r_state[0] ^ r_state[7]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= val;
      end else if (start_i) begin
         r_state <= w_next;
      end
   end

   assign result = r_state;
endmodule

// File: rtl/lfsr_step_ctrl.sv
// Loads the lfsr_2 core with a seed, steps it N times, then pulses done_o with the final state.
// Optional zero-seed substitution under macro LFSR_ZERO_GUARD_EN; latency N+2 cycles from accepted req_i.
module lfsr_step_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int               CNT_W        = 8,
   parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
   input  logic              clk_i,
   input  logic              rst_i,
   lfsr_step_ctrl_if.slave   bus
);
   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [LFSR_W-1:0] r_seed;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;
`ifdef LFSR_ZERO_GUARD_EN
   logic              r_zero_seed;
`endif

   logic              w_core_rst;
   logic [LFSR_W-1:0] w_core_val;
   logic              w_core_step;
   logic [LFSR_W-1:0] w_core_result;

   // During reset the core is seeded directly so result_o shows DEFAULT_SEED one cycle later.
   assign w_core_rst  = rst_i | (r_state == ST_LOAD);
   assign w_core_val  = rst_i ? DEFAULT_SEED : r_seed;
   assign w_core_step = (r_state == ST_RUN);

   lfsr_2 u_core (
      .clk_i   (clk_i),
      .rst_i   (w_core_rst),
      .val     (w_core_val),
      .start_i (w_core_step),
      .result  (w_core_result)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_seed  <= DEFAULT_SEED;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
         r_zero_seed <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.req_i) begin
                  r_cnt   <= bus.steps_i;
`ifdef LFSR_ZERO_GUARD_EN
                  r_seed      <= (bus.seed_i == 8'h00) ? DEFAULT_SEED : bus.seed_i;
                  r_zero_seed <= (bus.seed_i == 8'h00);
`else
                  r_seed  <= bus.seed_i;
`endif
                  r_state <= ST_LOAD;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (bus.abort_i) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // The core steps this cycle regardless of abort, so the count tracks it.
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end
               if (bus.abort_i) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_cnt == CNT_W'(1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready_o  = r_ready;
   assign bus.busy_o   = r_busy;
   assign bus.done_o   = r_done;
   assign bus.result_o = w_core_result;
`ifdef LFSR_ZERO_GUARD_EN
   assign bus.zero_seed_o = r_zero_seed;
`else
   assign bus.zero_seed_o = 1'b0;
`endif
endmodule
